// File: rtl/inst_decode_stage.sv
// Handshaked decode stage for the 16-bit RISC core: splits an instruction into
// ALU op, register selects, write enable and an extended immediate (IMX prefix aware).
module inst_decode_stage #(
    parameter int DATA_W     = 16,
    parameter int SEL_W      = 4,
    parameter int IMM_SIGNED = 1
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic              I_flush,
    input  logic              I_valid,
    output logic              O_ready,
    input  logic [15:0]       I_inst,
    output logic              O_valid,
    input  logic              I_ready,
    output logic [4:0]        O_aluop,
    output logic [SEL_W-1:0]  O_selA,
    output logic [SEL_W-1:0]  O_selB,
    output logic [SEL_W-1:0]  O_selD,
    output logic [DATA_W-1:0] O_imm,
    output logic              O_regwe,
    output logic              O_illegal,
    output logic              O_pfx_pending
);

    typedef enum logic [0:0] {
        PFX_IDLE = 1'b0,
        PFX_HELD = 1'b1
    } pfx_state_t;

    pfx_state_t        r_state;
    pfx_state_t        w_state_nxt;
    logic [7:0]        r_pfx;

    logic              r_valid;
    logic [4:0]        r_aluop;
    logic [SEL_W-1:0]  r_sel_a;
    logic [SEL_W-1:0]  r_sel_b;
    logic [SEL_W-1:0]  r_sel_d;
    logic [DATA_W-1:0] r_imm;
    logic              r_regwe;
    logic              r_illegal;

    logic              w_ready;
    logic              w_accept;
    logic              w_is_imx;
    logic              w_load;
    logic              w_illegal;
    logic              w_nowrite;
    logic              w_regwe;
    logic [DATA_W-1:0] w_imm_ext;
    logic [DATA_W-1:0] w_imm_pfx;
    logic [DATA_W-1:0] w_imm;

    assign w_ready  = !I_flush && (!r_valid || I_ready);
    assign w_accept = I_valid && w_ready;
    assign w_is_imx = (I_inst[15:11] == 5'b11111);
    assign w_load   = w_accept && !w_is_imx;

    // Field decode: reserved-opcode flag and register write enable.
    always_comb begin
        w_illegal = (I_inst[15:11] == 5'b11110);
        w_nowrite = 1'b0;
        case (I_inst[15:12])
            4'b0111: w_nowrite = 1'b1;
            4'b1100: w_nowrite = 1'b1;
            4'b1101: w_nowrite = 1'b1;
            default: w_nowrite = 1'b0;
        endcase
        w_regwe = !w_nowrite && !w_illegal;
    end

    // Immediate select; for an 8-bit datapath the cast keeps only I_inst[7:0], dropping the prefix.
    always_comb begin
        w_imm_ext = (IMM_SIGNED != 0) ? DATA_W'($signed(I_inst[7:0])) : DATA_W'(I_inst[7:0]);
        w_imm_pfx = DATA_W'({r_pfx, I_inst[7:0]});
        if (r_state == PFX_HELD) begin
            w_imm = w_imm_pfx;
        end else begin
            w_imm = w_imm_ext;
        end
    end

    // Prefix FSM next-state: flush wins, any accept decides PFX vs IDLE.
    always_comb begin
        w_state_nxt = r_state;
        if (I_flush) begin
            w_state_nxt = PFX_IDLE;
        end else if (w_accept) begin
            if (w_is_imx) begin
                w_state_nxt = PFX_HELD;
            end else begin
                w_state_nxt = PFX_IDLE;
            end
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Prefix FSM state and prefix payload registers.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state <= PFX_IDLE;
            r_pfx   <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            if (I_flush) begin
                r_pfx <= 8'h00;
            end else if (w_accept && w_is_imx) begin
                r_pfx <= I_inst[7:0];
            end else begin
                r_pfx <= r_pfx;
            end
        end
    end

    // One-entry output register: flush > load > drain > hold.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_valid   <= 1'b0;
            r_aluop   <= 5'd0;
            r_sel_a   <= '0;
            r_sel_b   <= '0;
            r_sel_d   <= '0;
            r_imm     <= '0;
            r_regwe   <= 1'b0;
            r_illegal <= 1'b0;
        end else if (I_flush) begin
            r_valid   <= 1'b0;
        end else if (w_load) begin
            r_valid   <= 1'b1;
            r_aluop   <= I_inst[15:11];
            r_sel_a   <= SEL_W'(I_inst[10:8]);
            r_sel_b   <= SEL_W'(I_inst[7:5]);
            r_sel_d   <= SEL_W'(I_inst[4:2]);
            r_imm     <= w_imm;
            r_regwe   <= w_regwe;
            r_illegal <= w_illegal;
        end else if (r_valid && I_ready) begin
            r_valid   <= 1'b0;
        end else begin
            r_valid   <= r_valid;
        end
    end

    assign O_ready       = w_ready;
    assign O_valid       = r_valid;
    assign O_aluop       = r_aluop;
    assign O_selA        = r_sel_a;
    assign O_selB        = r_sel_b;
    assign O_selD        = r_sel_d;
    assign O_imm         = r_imm;
    assign O_regwe       = r_regwe;
    assign O_illegal     = r_illegal;
    assign O_pfx_pending = (r_state == PFX_HELD);

endmodule

// File: tb/tb_inst_decode_stage.sv
// Bench for inst_decode_stage: directed test-plan steps followed by random traffic,
// both checked against a cycle-level model of what downstream should observe.
module tb_inst_decode_stage;

    logic        I_clk;
    logic        I_rst_n;
    logic        I_flush;
    logic        I_valid;
    logic [15:0] I_inst;
    logic        I_ready;

    logic        O_ready,   O_ready_u;
    logic        O_valid,   O_valid_u;
    logic [4:0]  O_aluop,   O_aluop_u;
    logic [3:0]  O_selA,    O_selA_u;
    logic [3:0]  O_selB,    O_selB_u;
    logic [3:0]  O_selD,    O_selD_u;
    logic [15:0] O_imm,     O_imm_u;
    logic        O_regwe,   O_regwe_u;
    logic        O_illegal, O_illegal_u;
    logic        O_pfx_pending, O_pfx_pending_u;

    int n_checks = 0;
    int n_fail   = 0;

    // model of the observable stage state
    logic        m_valid, m_pend;
    logic [7:0]  m_pfx;
    logic [4:0]  m_aluop;
    logic [3:0]  m_sa, m_sb, m_sd;
    logic [15:0] m_imm_s, m_imm_u;
    logic        m_regwe, m_ill;

    inst_decode_stage #(.DATA_W(16), .SEL_W(4), .IMM_SIGNED(1)) u_dut (
        .I_clk(I_clk), .I_rst_n(I_rst_n), .I_flush(I_flush), .I_valid(I_valid),
        .O_ready(O_ready), .I_inst(I_inst), .O_valid(O_valid), .I_ready(I_ready),
        .O_aluop(O_aluop), .O_selA(O_selA), .O_selB(O_selB), .O_selD(O_selD),
        .O_imm(O_imm), .O_regwe(O_regwe), .O_illegal(O_illegal),
        .O_pfx_pending(O_pfx_pending)
    );

    inst_decode_stage #(.DATA_W(16), .SEL_W(4), .IMM_SIGNED(0)) u_dut_u (
        .I_clk(I_clk), .I_rst_n(I_rst_n), .I_flush(I_flush), .I_valid(I_valid),
        .O_ready(O_ready_u), .I_inst(I_inst), .O_valid(O_valid_u), .I_ready(I_ready),
        .O_aluop(O_aluop_u), .O_selA(O_selA_u), .O_selB(O_selB_u), .O_selD(O_selD_u),
        .O_imm(O_imm_u), .O_regwe(O_regwe_u), .O_illegal(O_illegal_u),
        .O_pfx_pending(O_pfx_pending_u)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_valid = 1'b0; m_pend = 1'b0; m_pfx = 8'h00;
        m_aluop = 5'd0; m_sa = 4'd0; m_sb = 4'd0; m_sd = 4'd0;
        m_imm_s = 16'h0000; m_imm_u = 16'h0000; m_regwe = 1'b0; m_ill = 1'b0;
    endtask

    task automatic compare_all();
        chk("valid",     {31'd0, O_valid},         {31'd0, m_valid});
        chk("valid_u",   {31'd0, O_valid_u},       {31'd0, m_valid});
        chk("pfx_pend",  {31'd0, O_pfx_pending},   {31'd0, m_pend});
        chk("pfx_pend_u",{31'd0, O_pfx_pending_u}, {31'd0, m_pend});
        if (m_valid) begin
            chk("aluop",   {27'd0, O_aluop},   {27'd0, m_aluop});
            chk("selA",    {28'd0, O_selA},    {28'd0, m_sa});
            chk("selB",    {28'd0, O_selB},    {28'd0, m_sb});
            chk("selD",    {28'd0, O_selD},    {28'd0, m_sd});
            chk("imm_s",   {16'd0, O_imm},     {16'd0, m_imm_s});
            chk("imm_u",   {16'd0, O_imm_u},   {16'd0, m_imm_u});
            chk("regwe",   {31'd0, O_regwe},   {31'd0, m_regwe});
            chk("illegal", {31'd0, O_illegal}, {31'd0, m_ill});
            chk("regwe_u", {31'd0, O_regwe_u}, {31'd0, m_regwe});
        end
    endtask

    // One clock: drive inputs, check ready, advance the model, check registered outputs.
    task automatic step(input logic v, input logic [15:0] inst, input logic rdy, input logic fl);
        logic       exp_rdy;
        logic       acc;
        int         op;
        int         nib;
        int         low;
        I_valid = v; I_inst = inst; I_ready = rdy; I_flush = fl;
        #1;
        exp_rdy = !fl && (!m_valid || rdy);
        chk("o_ready",   {31'd0, O_ready},   {31'd0, exp_rdy});
        chk("o_ready_u", {31'd0, O_ready_u}, {31'd0, exp_rdy});
        acc = v && exp_rdy;
        op  = int'(inst) / 2048;
        nib = int'(inst) / 4096;
        low = int'(inst) % 256;
        if (fl) begin
            m_valid = 1'b0;
            m_pend  = 1'b0;
        end else if (acc && op == 31) begin
            m_pend = 1'b1;
            m_pfx  = 8'(low);
            if (m_valid && rdy) m_valid = 1'b0;
        end else if (acc) begin
            m_aluop = 5'(op);
            m_sa    = 4'((int'(inst) / 256) % 8);
            m_sb    = 4'((int'(inst) / 32) % 8);
            m_sd    = 4'((int'(inst) / 4) % 8);
            m_ill   = (op == 30);
            m_regwe = !(nib == 7 || nib == 12 || nib == 13) && !m_ill;
            if (m_pend) begin
                m_imm_s = 16'(int'(m_pfx) * 256 + low);
                m_imm_u = m_imm_s;
            end else begin
                m_imm_u = 16'(low);
                m_imm_s = (low >= 128) ? 16'(low + 65280) : 16'(low);
            end
            m_pend  = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        @(posedge I_clk);
        #1;
        compare_all();
    endtask

    // Reset asserted mid-cycle, away from any clock edge.
    task automatic async_reset();
        I_valid = 1'b0; I_flush = 1'b0;
        #2;
        I_rst_n = 1'b0;
        #1;
        chk("rst_valid", {31'd0, O_valid},       32'd0);
        chk("rst_pend",  {31'd0, O_pfx_pending}, 32'd0);
        chk("rst_ready", {31'd0, O_ready},       32'd1);
        model_clear();
        #2;
        I_rst_n = 1'b1;
        @(posedge I_clk);
        #1;
        compare_all();
    endtask

    initial begin
        logic [15:0] w;
        int sel;
        I_rst_n = 1'b0; I_flush = 1'b0; I_valid = 1'b0; I_inst = 16'h0000; I_ready = 1'b0;
        model_clear();
        #12;
        chk("reset_valid",   {31'd0, O_valid},       32'd0);
        chk("reset_aluop",   {27'd0, O_aluop},       32'd0);
        chk("reset_selA",    {28'd0, O_selA},        32'd0);
        chk("reset_imm",     {16'd0, O_imm},         32'd0);
        chk("reset_regwe",   {31'd0, O_regwe},       32'd0);
        chk("reset_illegal", {31'd0, O_illegal},     32'd0);
        chk("reset_pend",    {31'd0, O_pfx_pending}, 32'd0);
        chk("reset_ready",   {31'd0, O_ready},       32'd1);
        #1;
        I_rst_n = 1'b1;
        @(posedge I_clk);
        #1;

        step(1'b1, 16'h0A5C, 1'b1, 1'b0);
        chk("t1_valid", {31'd0, O_valid}, 32'd1);
        chk("t1_aluop", {27'd0, O_aluop}, 32'h01);
        chk("t1_selA",  {28'd0, O_selA},  32'd2);
        chk("t1_selB",  {28'd0, O_selB},  32'd2);
        chk("t1_selD",  {28'd0, O_selD},  32'd7);
        chk("t1_imm",   {16'd0, O_imm},   32'h005C);
        chk("t1_regwe", {31'd0, O_regwe}, 32'd1);
        chk("t1_ill",   {31'd0, O_illegal}, 32'd0);

        step(1'b1, 16'h7000, 1'b1, 1'b0);
        chk("nowr_7", {31'd0, O_regwe}, 32'd0);
        step(1'b1, 16'hC812, 1'b1, 1'b0);
        chk("nowr_C", {31'd0, O_regwe}, 32'd0);
        step(1'b1, 16'hF000, 1'b1, 1'b0);
        chk("ill_flag",  {31'd0, O_illegal}, 32'd1);
        chk("ill_regwe", {31'd0, O_regwe},   32'd0);

        step(1'b1, 16'h0880, 1'b1, 1'b0);
        chk("sext_imm", {16'd0, O_imm},   32'hFF80);
        chk("zext_imm", {16'd0, O_imm_u}, 32'h0080);

        step(1'b1, 16'hF812, 1'b1, 1'b0);
        chk("imx_novalid", {31'd0, O_valid},       32'd0);
        chk("imx_pend",    {31'd0, O_pfx_pending}, 32'd1);
        step(1'b1, 16'h0834, 1'b1, 1'b0);
        chk("pfx_imm",  {16'd0, O_imm},         32'h1234);
        chk("pfx_done", {31'd0, O_pfx_pending}, 32'd0);
        step(1'b1, 16'hF811, 1'b1, 1'b0);
        step(1'b1, 16'hF822, 1'b1, 1'b0);
        step(1'b1, 16'h0833, 1'b1, 1'b0);
        chk("pfx2_imm", {16'd0, O_imm}, 32'h2233);

        step(1'b1, 16'h1111, 1'b1, 1'b0);
        step(1'b1, 16'h2222, 1'b0, 1'b0);
        step(1'b1, 16'h3333, 1'b0, 1'b0);
        step(1'b1, 16'h4444, 1'b0, 1'b0);
        chk("bp_frozen", {16'd0, O_imm}, 32'h0011);
        step(1'b1, 16'h5555, 1'b1, 1'b0);
        chk("bp_next1", {16'd0, O_imm}, 32'h0055);
        step(1'b1, 16'h6666, 1'b1, 1'b0);
        chk("bp_next2", {16'd0, O_imm}, 32'h0066);
        step(1'b0, 16'h0000, 1'b1, 1'b0);

        step(1'b1, 16'hF812, 1'b1, 1'b0);
        step(1'b1, 16'h0834, 1'b1, 1'b1);
        chk("flush_pend",  {31'd0, O_pfx_pending}, 32'd0);
        chk("flush_valid", {31'd0, O_valid},       32'd0);
        step(1'b1, 16'h0834, 1'b1, 1'b0);
        chk("flush_imm", {16'd0, O_imm}, 32'h0034);

        step(1'b1, 16'h0A5C, 1'b0, 1'b0);
        async_reset();
        step(1'b1, 16'hF8AB, 1'b1, 1'b0);
        async_reset();

        for (int i = 0; i < 3000; i++) begin
            w   = 16'($urandom);
            sel = $urandom_range(0, 9);
            if (sel < 2)       w[15:11] = 5'b11111;
            else if (sel == 2) w[15:11] = 5'b11110;
            else               w = w;
            step($urandom_range(0, 3) != 0, w, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_decode_stage.md
Name: inst_decode_stage

Overview:
- Parametrised, handshaked instruction-decode pipeline stage for the 16-bit RISC core. It sits between fetch and register-file/ALU issue.
- Splits each 16-bit instruction into opcode, register selects, write-enable and an extended immediate.
- Adds a valid/ready handshake, a one-entry output register with stall, an immediate-prefix (IMX) state machine for full-width immediates, illegal-opcode flagging, and flush.

Parameters:
- DATA_W, 16: width of O_imm. Legal values are 8 and 16.
- SEL_W, 4: width of the O_selA/O_selB/O_selD outputs. The 3-bit instruction fields are zero-extended to this width. Must be >= 3.
- IMM_SIGNED, 1: 1 = sign-extend the 8-bit immediate when no prefix is pending; 0 = zero-extend.

Ports:
- I_clk  in  1  clock; all state updates on the rising edge.
- I_rst_n  in  1  asynchronous, active-low reset.
- I_flush  in  1  synchronous flush; clears O_valid and the prefix state.
- I_valid  in  1  I_inst is valid.
- O_ready  out  1  stage can accept I_inst this cycle.
- I_inst  in  16  instruction word.
- O_valid  out  1  decoded outputs are valid.
- I_ready  in  1  downstream accepts the decoded outputs.
- O_aluop  out  5  I_inst[15:11].
- O_selA  out  SEL_W  I_inst[10:8], zero-extended.
- O_selB  out  SEL_W  I_inst[7:5], zero-extended.
- O_selD  out  SEL_W  I_inst[4:2], zero-extended.
- O_imm  out  DATA_W  extended immediate.
- O_regwe  out  1  register write enable.
- O_illegal  out  1  reserved opcode decoded.
- O_pfx_pending  out  1  an IMX prefix is held.

Behaviour:
- Reset (I_rst_n=0, asynchronous):
  - O_valid, O_aluop, O_selA/B/D, O_imm, O_regwe, O_illegal = 0.
  - Prefix state = IDLE; prefix register = 0.
  - O_ready comes out as 1 combinationally once O_valid=0.
- Handshake:
  - O_ready = !O_valid || I_ready (combinational). Full throughput: one instruction per cycle.
  - Accept = I_valid && O_ready. Output transfer = O_valid && I_ready.
  - Latency: an accepted non-prefix instruction appears with O_valid=1 on the next rising edge.
  - While O_valid=1 and I_ready=0, all outputs hold stable.
  - If a transfer happens and there is no new accept in the same cycle, O_valid goes to 0.
- Decode (applies only on accept of a non-IMX instruction):
  - O_regwe = 0 when I_inst[15:12] is 0111, 1100 or 1101, and also when O_illegal=1. Otherwise O_regwe = 1.
  - O_illegal = 1 when the opcode is 5'b11110. In that case O_regwe is forced to 0; the other fields still decode normally.
- Immediate:
  - IDLE: O_imm = I_inst[7:0], sign-extended if IMM_SIGNED=1, else zero-extended.
  - PFX: if DATA_W=16, O_imm = {pfx[7:0], I_inst[7:0]}. If DATA_W=8, O_imm = I_inst[7:0] and the prefix is discarded.
- Prefix FSM (states IDLE, PFX):
  - Accept of opcode 5'b11111 (IMX): pfx <= I_inst[7:0]; state -> PFX. No output is produced and O_valid is not set.
  - Accept of IMX while in PFX: overwrite pfx; stay in PFX.
  - Accept of a non-IMX instruction in PFX: use pfx for O_imm; state -> IDLE.
  - O_pfx_pending = (state == PFX).
- Flush (I_flush=1 at a rising edge):
  - O_valid <= 0 and state <= IDLE.
  - Any I_inst offered that cycle is not accepted: O_ready is forced to 0 while I_flush=1.
  - Flush takes priority over accept and over transfer.
- Reset mid-operation: a pending prefix and any held output are discarded immediately.

Test Plan:
- Reset, then I_inst=16'h0A5C with I_valid=1, I_ready=1 -> next cycle:
  - O_valid=1, O_aluop=5'h01, O_selA=2, O_selB=2, O_selD=7, O_imm=16'h005C, O_regwe=1, O_illegal=0.
- I_inst=16'h7000 (top nibble 0111), then 16'hC812 -> O_regwe=0 for both. Then 16'hF000 -> O_illegal=1, O_regwe=0.
- Signed immediate: I_inst=16'h0880 with IMM_SIGNED=1 -> O_imm=16'hFF80. Same instruction with IMM_SIGNED=0 -> O_imm=16'h0080.
- Prefix: IMX 16'hF812 then 16'h0834:
  - After IMX: no O_valid, O_pfx_pending=1.
  - After second instruction: O_imm=16'h1234, O_pfx_pending=0.
  - Two IMX in a row (16'hF811, 16'hF822) then 16'h0833 -> O_imm=16'h2233.
- Back-pressure: hold I_ready=0 for 3 cycles with I_valid=1 and different words offered:
  - O_ready=0 and outputs frozen on the first word.
  - On I_ready=1, back-to-back words appear one per cycle with no drop or duplicate.
- Flush/reset:
  - IMX accepted, then I_flush=1 -> O_pfx_pending=0 and O_valid=0; a following 16'h0834 yields O_imm=16'h0034.
  - Assert I_rst_n=0 asynchronously between clock edges while O_valid=1 -> O_valid=0 immediately.
